i2s_stereo_receiver: RTL and testbench

Parametrised stereo I2S / left-justified receiver for ADC input; successor to the single-channel capture block.
Oversamples bclk/lrclk/data in the clk_i domain and deserialises both channels of each frame with configurable word and slot widths.
Delivers an aligned left/right sample pair with a one-cycle valid strobe and flags malformed slots.
Sits between the i2s_if pins and the DSP input stage.

---
 rtl/i2s_pkg.sv | 23 ++
 rtl/i2s_if.sv | 12 +
 rtl/i2s_edge_sync.sv | 41 ++++
 rtl/i2s_stereo_receiver.sv | 141 ++++++++++++++
 tb/tb_i2s_stereo_receiver.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive/transmit blocks.
package i2s_pkg;

    typedef enum logic {
        I2S_FMT = 1'b0,
        LJ_FMT  = 1'b1
    } fmt_e;

    typedef enum logic [1:0] {
        SYNC_S  = 2'd0,
        LEFT_S  = 2'd1,
        RIGHT_S = 2'd2
    } state_e;

    localparam int MAX_SLOT_WIDTH = 32;
    localparam int CNT_W          = $clog2(MAX_SLOT_WIDTH + 1);

    // Index within a slot of the MSB: one bclk late in I2S, on the edge in LJ.
    function automatic int fmt_offset(fmt_e fmt);
        return (fmt == I2S_FMT) ? 1 : 0;
    endfunction

endpackage

// File: rtl/i2s_if.sv
// I2S pin bundle; the receiver only listens to the ADC side.
interface i2s_if;
    logic bclk;
    logic lrclk;
    logic data_from_adc;

    modport rx (
        input bclk,
        input lrclk,
        input data_from_adc
    );
endinterface

// File: rtl/i2s_edge_sync.sv
// Synchronises the I2S pins into clk_i and flags bclk rising edges.
// rise/lrclk_s/data_s are registered together so they stay aligned.
module i2s_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic bclk,
    input  logic lrclk,
    input  logic data,
    output logic rise,
    output logic lrclk_s,
    output logic data_s
);

    logic [SYNC_STAGES-1:0] bclk_sr;
    logic [SYNC_STAGES-1:0] lrclk_sr;
    logic [SYNC_STAGES-1:0] data_sr;
    logic                   bclk_d;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            bclk_sr  <= '0;
            lrclk_sr <= '0;
            data_sr  <= '0;
            bclk_d   <= 1'b0;
            rise     <= 1'b0;
            lrclk_s  <= 1'b0;
            data_s   <= 1'b0;
        end else begin
            bclk_sr  <= {bclk_sr[SYNC_STAGES-2:0], bclk};
            lrclk_sr <= {lrclk_sr[SYNC_STAGES-2:0], lrclk};
            data_sr  <= {data_sr[SYNC_STAGES-2:0], data};
            bclk_d   <= bclk_sr[SYNC_STAGES-1];
            rise     <= bclk_sr[SYNC_STAGES-1] & ~bclk_d;
            lrclk_s  <= lrclk_sr[SYNC_STAGES-1];
            data_s   <= data_sr[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/i2s_stereo_receiver.sv
// Stereo I2S / left-justified ADC receiver: deserialises a left/right pair
// per frame and flags slots whose bclk count differs from SLOT_WIDTH.
module i2s_stereo_receiver
    import i2s_pkg::*;
#(
    parameter int    DATA_WIDTH  = 16,
    parameter int    SLOT_WIDTH  = 32,
    parameter string FORMAT      = "I2S",
    parameter int    SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    i2s_if.rx                     i2s,
    output logic [DATA_WIDTH-1:0] left_o,
    output logic [DATA_WIDTH-1:0] right_o,
    output logic                  sample_val_o,
    output logic                  slot_err_o,
    output logic [1:0]            fsm_state_o
);

    localparam fmt_e FMT      = (FORMAT == "LJ") ? LJ_FMT : I2S_FMT;
    localparam int   OFF      = fmt_offset(FMT);
    localparam logic LEFT_POL = (FMT == LJ_FMT);

    logic rise;
    logic lrclk_s;
    logic data_s;

    i2s_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk_i   (clk_i),
        .srst_i  (srst_i),
        .bclk    (i2s.bclk),
        .lrclk   (i2s.lrclk),
        .data    (i2s.data_from_adc),
        .rise    (rise),
        .lrclk_s (lrclk_s),
        .data_s  (data_s)
    );

    state_e                state_q, state_d;
    logic                  lr_prev_q;
    logic                  lr_valid_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [DATA_WIDTH-1:0] left_word_q;
    logic                  left_ok_q;

    logic                  boundary;
    logic                  slot_close;
    logic [CNT_W:0]        bits_seen;
    logic                  count_bad;
    logic                  word_done;
    logic [CNT_W-1:0]      idx;
    logic [CNT_W-1:0]      cap_pos;
    logic                  cap_en;

    assign fsm_state_o = state_q;

    always_ff @(posedge clk_i) begin
        if (srst_i) state_q <= SYNC_S;
        else        state_q <= state_d;
    end

    // The first rise after reset only primes lr_prev_q, so a reset inside a
    // slot can never be mistaken for a boundary.
    always_comb begin
        boundary   = rise && lr_valid_q && (lrclk_s != lr_prev_q);
        slot_close = boundary && (state_q != SYNC_S);
        bits_seen  = {1'b0, bit_cnt_q} + 1'b1;
        count_bad  = (bits_seen != (CNT_W+1)'(SLOT_WIDTH));
        word_done  = (bits_seen >= (CNT_W+1)'(OFF + DATA_WIDTH));

        state_d = state_q;
        case (state_q)
            SYNC_S:  if (boundary && (lrclk_s == LEFT_POL)) state_d = LEFT_S;
            LEFT_S:  if (boundary) state_d = RIGHT_S;
            RIGHT_S: if (boundary) state_d = LEFT_S;
            default: state_d = SYNC_S;
        endcase
    end

    // Index of the current rise within the slot; saturates at SLOT_WIDTH.
    always_comb begin
        if (boundary)
            idx = '0;
        else if (bit_cnt_q >= CNT_W'(SLOT_WIDTH))
            idx = CNT_W'(SLOT_WIDTH);
        else
            idx = bit_cnt_q + 1'b1;

        cap_en  = rise && (idx >= CNT_W'(OFF)) && (idx < CNT_W'(OFF + DATA_WIDTH));
        cap_pos = CNT_W'(DATA_WIDTH - 1 + OFF) - idx;

        sh_d = boundary ? '0 : sh_q;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (cap_en && (cap_pos == CNT_W'(i))) sh_d[i] = data_s;
        end
    end

    // sample_val_o: one-cycle strobe; left_o/right_o hold until the next one.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            lr_prev_q    <= 1'b0;
            lr_valid_q   <= 1'b0;
            bit_cnt_q    <= '0;
            sh_q         <= '0;
            left_word_q  <= '0;
            left_ok_q    <= 1'b0;
            left_o       <= '0;
            right_o      <= '0;
            sample_val_o <= 1'b0;
            slot_err_o   <= 1'b0;
        end else begin
            sample_val_o <= 1'b0;
            slot_err_o   <= 1'b0;
            if (rise) begin
                lr_prev_q  <= lrclk_s;
                lr_valid_q <= 1'b1;
                bit_cnt_q  <= idx;
                sh_q       <= sh_d;
            end
            if (slot_close) begin
                slot_err_o <= count_bad;
                if (state_q == LEFT_S) begin
                    left_word_q <= sh_q;
                    left_ok_q   <= word_done;
                end else begin
                    left_ok_q <= 1'b0;
                    if (word_done && left_ok_q) begin
                        left_o       <= left_word_q;
                        right_o      <= sh_q;
                        sample_val_o <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_stereo_receiver.sv
// Directed bench: bus a feeds I2S receivers (16- and 24-bit), bus b feeds an
// LJ receiver; every slot is driven on both buses in lock-step.
module tb_i2s_stereo_receiver;
    import i2s_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic srst = 1'b1;
    int   cyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- pins ----------------
    logic bclk = 1'b0;
    logic lr_a = 1'b0, dat_a = 1'b0;
    logic lr_b = 1'b0, dat_b = 1'b0;

    i2s_if bus_a ();
    i2s_if bus_b ();
    assign bus_a.bclk          = bclk;
    assign bus_a.lrclk         = lr_a;
    assign bus_a.data_from_adc = dat_a;
    assign bus_b.bclk          = bclk;
    assign bus_b.lrclk         = lr_b;
    assign bus_b.data_from_adc = dat_b;

    logic [15:0] a16_l, a16_r, b16_l, b16_r;
    logic [23:0] a24_l, a24_r;
    logic        a16_val, a16_err, b16_val, b16_err, a24_val, a24_err;
    logic [1:0]  a16_st, b16_st, a24_st;

    i2s_stereo_receiver #(
        .DATA_WIDTH(16), .SLOT_WIDTH(32), .FORMAT("I2S"), .SYNC_STAGES(2)
    ) dut_a16 (
        .clk_i(clk), .srst_i(srst), .i2s(bus_a),
        .left_o(a16_l), .right_o(a16_r), .sample_val_o(a16_val),
        .slot_err_o(a16_err), .fsm_state_o(a16_st)
    );

    i2s_stereo_receiver #(
        .DATA_WIDTH(16), .SLOT_WIDTH(32), .FORMAT("LJ"), .SYNC_STAGES(2)
    ) dut_b16 (
        .clk_i(clk), .srst_i(srst), .i2s(bus_b),
        .left_o(b16_l), .right_o(b16_r), .sample_val_o(b16_val),
        .slot_err_o(b16_err), .fsm_state_o(b16_st)
    );

    i2s_stereo_receiver #(
        .DATA_WIDTH(24), .SLOT_WIDTH(32), .FORMAT("I2S"), .SYNC_STAGES(2)
    ) dut_a24 (
        .clk_i(clk), .srst_i(srst), .i2s(bus_a),
        .left_o(a24_l), .right_o(a24_r), .sample_val_o(a24_val),
        .slot_err_o(a24_err), .fsm_state_o(a24_st)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    localparam int LAT = 4;   // SYNC_STAGES + 2
    logic [31:0] exp_a16_q[$];
    logic [31:0] exp_b16_q[$];
    logic [47:0] exp_a24_q[$];
    int bnd_cyc = 0;
    int a16_errs = 0, b16_errs = 0, a24_errs = 0;

    always @(negedge clk) begin
        if (a16_val) begin
            if (exp_a16_q.size() == 0) check("a16_extra", exp_a16_q.size(), 1);
            else begin
                check("a16_pair", {a16_l, a16_r}, exp_a16_q.pop_front());
                check("a16_lat", cyc - bnd_cyc, LAT);
            end
        end
        if (b16_val) begin
            if (exp_b16_q.size() == 0) check("b16_extra", exp_b16_q.size(), 1);
            else begin
                check("b16_pair", {b16_l, b16_r}, exp_b16_q.pop_front());
                check("b16_lat", cyc - bnd_cyc, LAT);
            end
        end
        if (a24_val) begin
            if (exp_a24_q.size() == 0) check("a24_extra", exp_a24_q.size(), 1);
            else begin
                check("a24_pair", {a24_l, a24_r}, exp_a24_q.pop_front());
                check("a24_lat", cyc - bnd_cyc, LAT);
            end
        end
        if (a16_err) a16_errs++;
        if (b16_err) b16_errs++;
        if (a24_err) a24_errs++;
    end

    // ---------------- drivers ----------------
    function automatic logic [31:0] vec_i2s24(input logic [23:0] w);
        return {1'b0, w, 7'b0};
    endfunction
    function automatic logic [31:0] vec_i2s16(input logic [15:0] w);
        return {1'b0, w, 15'b0};
    endfunction
    function automatic logic [31:0] vec_lj16(input logic [15:0] w);
        return {w, 16'b0};
    endfunction

    // One slot of nbits bclks; va/vb hold the bit for slot index k at [31-k].
    task automatic send_slot(input logic left, input logic [31:0] va,
                             input logic [31:0] vb, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            @(negedge clk);
            bclk  = 1'b0;
            lr_a  = left ? 1'b0 : 1'b1;
            lr_b  = left ? 1'b1 : 1'b0;
            dat_a = (k < 32) ? va[31-k] : 1'b0;
            dat_b = (k < 32) ? vb[31-k] : 1'b0;
            repeat (4) @(negedge clk);
            bclk = 1'b1;
            if (left && k == 0) bnd_cyc = cyc;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [23:0] la, input logic [23:0] ra,
                              input logic [31:0] vbl, input logic [31:0] vbr);
        send_slot(1'b1, vec_i2s24(la), vbl, 32);
        send_slot(1'b0, vec_i2s24(ra), vbr, 32);
    endtask

    task automatic expect_frame(input logic [23:0] la, input logic [23:0] ra,
                                input logic [15:0] lb, input logic [15:0] rb);
        exp_a16_q.push_back({la[23:8], ra[23:8]});
        exp_a24_q.push_back({la, ra});
        exp_b16_q.push_back({lb, rb});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_a16_out"}, {a16_l, a16_r, a16_val, a16_err}, 0);
        check({tag, "_b16_out"}, {b16_l, b16_r, b16_val, b16_err}, 0);
        check({tag, "_a24_out"}, {a24_l, a24_r, a24_val, a24_err}, 0);
        check({tag, "_a16_fsm"}, a16_st, SYNC_S);
        check({tag, "_b16_fsm"}, b16_st, SYNC_S);
        check({tag, "_a24_fsm"}, a24_st, SYNC_S);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (5) @(negedge clk);
        check_reset_state("rst");
        srst = 1'b0;

        // Partial right slot for the receivers to sync on.
        send_slot(1'b0, 32'h0, 32'h0, 32);

        // Basic frames; b carries the same words LJ-timed.
        repeat (3) begin
            expect_frame(24'h800100, 24'h7FFE00, 16'h8001, 16'h7FFE);
            send_frame(24'h800100, 24'h7FFE00, vec_lj16(16'h8001), vec_lj16(16'h7FFE));
        end

        // 24-bit words on a; b gets I2S-timed data so LJ sees it one bit late.
        repeat (2) begin
            expect_frame(24'hA5A5A5, 24'h5A5A5A, 16'h4000, 16'h3FFF);
            send_frame(24'hA5A5A5, 24'h5A5A5A, vec_i2s16(16'h8001), vec_i2s16(16'h7FFE));
        end
        check("a16_errs_clean", a16_errs, 0);
        check("b16_errs_clean", b16_errs, 0);
        check("a24_errs_clean", a24_errs, 0);

        // Reset in the middle of a left slot.
        send_slot(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10);
        @(negedge clk);
        srst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("midrst");
        srst = 1'b0;
        send_slot(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 22);
        send_slot(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
        expect_frame(24'h123456, 24'hABCDEF, 16'h1234, 16'hABCD);
        send_frame(24'h123456, 24'hABCDEF, vec_lj16(16'h1234), vec_lj16(16'hABCD));

        // Short right slot: error, pair dropped, outputs hold.
        send_slot(1'b1, vec_i2s24(24'h111111), vec_lj16(16'h1111), 32);
        send_slot(1'b0, vec_i2s24(24'h222222), vec_lj16(16'h2222), 10);
        expect_frame(24'hC0FFEE, 24'h0BADF0, 16'hC0FF, 16'h0BAD);
        send_slot(1'b1, vec_i2s24(24'hC0FFEE), vec_lj16(16'hC0FF), 32);
        check("a16_hold", {a16_l, a16_r}, 32'h1234_ABCD);
        check("b16_hold", {b16_l, b16_r}, 32'h1234_ABCD);
        check("a24_hold", {a24_l, a24_r}, 48'h123456_ABCDEF);
        check("a16_errs_short", a16_errs, 1);
        check("b16_errs_short", b16_errs, 1);
        check("a24_errs_short", a24_errs, 1);
        send_slot(1'b0, vec_i2s24(24'h0BADF0), vec_lj16(16'h0BAD), 32);

        // Long left slot: error, pair still delivered.
        expect_frame(24'h876543, 24'hFEDCBA, 16'h8765, 16'hFEDC);
        send_slot(1'b1, vec_i2s24(24'h876543), vec_lj16(16'h8765), 33);
        send_slot(1'b0, vec_i2s24(24'hFEDCBA), vec_lj16(16'hFEDC), 32);

        // Trailing left boundary closes the last right slot.
        send_slot(1'b1, 32'h0, 32'h0, 4);
        repeat (20) @(negedge clk);

        check("a16_q_empty", exp_a16_q.size(), 0);
        check("b16_q_empty", exp_b16_q.size(), 0);
        check("a24_q_empty", exp_a24_q.size(), 0);
        check("a16_errs_end", a16_errs, 2);
        check("b16_errs_end", b16_errs, 2);
        check("a24_errs_end", a24_errs, 2);
        check("a16_last", {a16_l, a16_r}, 32'h8765_FEDC);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
